pll_supervisor: RTL
===================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before declaring lock.
REQ-002 SHALL have parameter RELOCK_TIMEOUT, default 65536: maximum cycles to wait for lock before re-pulsing PLL reset.
REQ-003 SHALL have parameter RST_PULSE_CYCLES, default 16: width of the pll_reset pulse.
REQ-004 SHALL have parameter NUM_RST, default 2: number of sequenced downstream reset outputs.
REQ-005 SHALL have parameter RST_STAGGER, default 8: cycles between successive rst_out releases.
REQ-006 SHALL have parameter PS_SETTLE, default 32: cycles held after a phase/duty update before acknowledging.
REQ-007 SHALL have port clkin, input, 1: the only clock, the PLL reference clock.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port pll_lock, input, 1: raw PLL LOCK, asynchronous to clkin.
REQ-010 SHALL have port pll_reset, output, 1: drives the PLL RESET input.
REQ-011 SHALL have port pll_psda, output, 4: dynamic phase select to the PLL.
REQ-012 SHALL have port pll_dutyda, output, 4: dynamic duty select to the PLL.
REQ-013 SHALL have port ps_req, input, 1: phase/duty update request (level; held until ps_ack).
REQ-014 SHALL have ports ps_val and duty_val, input, 4 each: requested phase and duty codes.
REQ-015 SHALL have port ps_ack, output, 1: single-cycle update-complete pulse.
REQ-016 SHALL have port locked, output, 1: lock is stable.
REQ-017 SHALL have port rst_out, output, NUM_RST: active-high downstream resets.
REQ-018 SHALL have port relock_cnt, output, 8: saturating lock-loss/timeout counter.
REQ-019 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-020 SHALL synchronise pll_lock through two flops (lock_s); all decisions use lock_s, giving 2-cycle input latency.
REQ-021 SHALL implement FSM states RST_PLL, WAIT_LOCK, STABLE, RUN and PHASE.
- RST_PLL: pll_reset=1 for RST_PULSE_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: lock_s=1 -> STABLE; RELOCK_TIMEOUT cycles without lock -> RST_PLL, relock_cnt+1.
- STABLE: lock_s held LOCK_STABLE_CYCLES consecutive cycles -> RUN; lock_s=0 -> WAIT_LOCK with counter cleared, no relock_cnt increment.
- RUN: lock_s=0 -> RST_PLL, relock_cnt+1; ps_req=1 -> PHASE.
- PHASE: latch ps_val/duty_val onto pll_psda/pll_dutyda on entry; hold PS_SETTLE cycles; pulse ps_ack for one cycle; return to RUN.
REQ-022 SHALL assert locked only in RUN and PHASE; locked SHALL drop on the same edge the FSM leaves those states.
REQ-023 SHALL deassert rst_out[0] on the edge locked rises and rst_out[i] RST_STAGGER*i cycles later.
REQ-024 SHALL reassert every rst_out bit on the edge locked falls, including partway through the release sequence.
REQ-025 SHALL ignore ps_req outside RUN; a request held across relock SHALL be serviced after RUN is re-entered.
REQ-026 SHALL handle lock loss in PHASE as follows: go to RST_PLL, give no ps_ack, keep the latched pll_psda/pll_dutyda.
REQ-027 SHALL saturate relock_cnt at 255.

Reset
REQ-028 SHALL, while reset=1, force: state=RST_PLL, pll_reset=1, pll_psda=4'b0000, pll_dutyda=4'b1000, locked=0, rst_out all 1, ps_ack=0, relock_cnt=0, and both synchroniser and all counters cleared.
REQ-029 SHALL begin the RST_PLL pulse count on the first clkin edge after reset deasserts.

Structure
REQ-030 SHALL take the FSM state encoding and the parameter default constants from shared package pll_sup_pkg.
REQ-031 SHALL implement the two-flop synchroniser as sub-module lock_sync.
REQ-032 SHALL size each counter by $clog2 of its governing parameter.

Verification (LOCK_STABLE_CYCLES=8, RELOCK_TIMEOUT=32, RST_PULSE_CYCLES=4, NUM_RST=3, RST_STAGGER=2, PS_SETTLE=4)
REQ-033 SHALL check power-up: reset release, pll_lock=1 from cycle 0 -> pll_reset high for 4 cycles; locked rises 2 sync + 8 stable cycles after WAIT_LOCK; rst_out releases at +0/+2/+4.
REQ-034 SHALL check timeout: pll_lock held 0 -> pll_reset re-pulses every 36 cycles; relock_cnt increments 1,2,3.
REQ-035 SHALL check glitch: pll_lock low 1 cycle at stable count 5 -> FSM returns to WAIT_LOCK, relock_cnt unchanged, locked rises 8 cycles after the restored lock.
REQ-036 SHALL check phase update: in RUN, ps_req with ps_val=5, duty_val=6 -> pll_psda=5, pll_dutyda=6 on the next edge, ps_ack one cycle after 4 settle cycles.
REQ-037 SHALL check lock loss mid-stagger and in PHASE: all rst_out reassert next edge, no ps_ack, relock_cnt+1, pll_psda retained.
REQ-038 SHALL check saturation: 300 timeouts -> relock_cnt=255.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL supervisor: FSM encoding, parameter defaults
// and counter sizing helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        PHASE     = 3'd4
    } sup_state_t;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RELOCK_TIMEOUT     = 65536;
    localparam int DEF_RST_PULSE_CYCLES   = 16;
    localparam int DEF_NUM_RST            = 2;
    localparam int DEF_RST_STAGGER        = 8;
    localparam int DEF_PS_SETTLE          = 32;

    localparam logic [3:0] PSDA_RST = 4'b0000;
    localparam logic [3:0] DUTY_RST = 4'b1000;

    // Counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_supervisor_lock_sync.sv
// Two-flop synchroniser for the raw PLL lock; clr holds it at zero while the
// PLL itself is held in reset, so a stale lock is never trusted.
module lock_sync (
    input  logic clkin,
    input  logic reset,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else if (clr) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses PLL reset, qualifies lock, sequences downstream
// resets and services dynamic phase/duty updates.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RELOCK_TIMEOUT     = DEF_RELOCK_TIMEOUT,
    parameter int RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
    parameter int NUM_RST            = DEF_NUM_RST,
    parameter int RST_STAGGER        = DEF_RST_STAGGER,
    parameter int PS_SETTLE          = DEF_PS_SETTLE
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [3:0]         pll_psda,
    output logic [3:0]         pll_dutyda,
    input  logic               ps_req,
    input  logic [3:0]         ps_val,
    input  logic [3:0]         duty_val,
    output logic               ps_ack,
    output logic               locked,
    output logic [NUM_RST-1:0] rst_out,
    output logic [7:0]         relock_cnt,
    output logic [2:0]         state
);

    localparam int PULSE_W = cnt_w(RST_PULSE_CYCLES);
    localparam int TO_W    = cnt_w(RELOCK_TIMEOUT);
    localparam int STAB_W  = cnt_w(LOCK_STABLE_CYCLES);
    localparam int SET_W   = cnt_w(PS_SETTLE);
    localparam int STG_MAX = (NUM_RST - 1) * RST_STAGGER;
    localparam int STG_W   = cnt_w(STG_MAX + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    sup_state_t         st, st_nxt;
    logic [PULSE_W-1:0] pulse_cnt, pulse_nxt;
    logic [TO_W-1:0]    to_cnt, to_nxt;
    logic [STAB_W-1:0]  stab_cnt, stab_nxt;
    logic [SET_W-1:0]   set_cnt, set_nxt;
    logic [STG_W-1:0]   stg_cnt, stg_nxt;
    logic [NUM_RST-1:0] rst_nxt;
    logic               lock_s, relock_inc, ack_nxt, latch_ps, lock_nxt;

    lock_sync u_lock_sync (
        .clkin (clkin),
        .reset (reset),
        .clr   (st == RST_PLL),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign pll_reset = (st == RST_PLL);
    assign state     = st;

    // Counters default to zero so every state entry starts a fresh count.
    always_comb begin
        st_nxt     = st;
        pulse_nxt  = '0;
        to_nxt     = '0;
        stab_nxt   = '0;
        set_nxt    = '0;
        relock_inc = 1'b0;
        ack_nxt    = 1'b0;
        latch_ps   = 1'b0;
        unique case (st)
            RST_PLL: begin
                if (pulse_cnt == PULSE_W'(RST_PULSE_CYCLES - 1)) st_nxt = WAIT_LOCK;
                else pulse_nxt = pulse_cnt + 1'b1;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    st_nxt   = STABLE;
                    stab_nxt = STAB_W'(1);
                end else if (to_cnt == TO_W'(RELOCK_TIMEOUT - 1)) begin
                    st_nxt     = RST_PLL;
                    relock_inc = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) st_nxt = WAIT_LOCK;
                else if (stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1)) st_nxt = RUN;
                else stab_nxt = stab_cnt + 1'b1;
            end
            RUN: begin
                if (!lock_s) begin
                    st_nxt     = RST_PLL;
                    relock_inc = 1'b1;
                end else if (ps_req) begin
                    st_nxt   = PHASE;
                    latch_ps = 1'b1;
                end
            end
            PHASE: begin
                // Ack is shown while still in PHASE so a held ps_req is not re-taken.
                if (!lock_s) begin
                    st_nxt     = RST_PLL;
                    relock_inc = 1'b1;
                end else if (ps_ack) begin
                    st_nxt = RUN;
                end else if (set_cnt == SET_W'(PS_SETTLE - 1)) begin
                    ack_nxt = 1'b1;
                end else begin
                    set_nxt = set_cnt + 1'b1;
                end
            end
            default: st_nxt = RST_PLL;
        endcase
    end

    // Release schedule is keyed off the next locked value so rst_out moves on the same edge.
    always_comb begin
        lock_nxt = (st_nxt == RUN) || (st_nxt == PHASE);
        stg_nxt  = '0;
        rst_nxt  = '1;
        if (lock_nxt && locked) begin
            stg_nxt = (stg_cnt == STG_W'(STG_MAX)) ? stg_cnt : stg_cnt + 1'b1;
        end
        for (int i = 0; i < NUM_RST; i++) begin
            rst_nxt[i] = !(lock_nxt && (int'(stg_nxt) >= i * RST_STAGGER));
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            st         <= RST_PLL;
            pulse_cnt  <= '0;
            to_cnt     <= '0;
            stab_cnt   <= '0;
            set_cnt    <= '0;
            stg_cnt    <= '0;
            relock_cnt <= '0;
            ps_ack     <= 1'b0;
            locked     <= 1'b0;
            rst_out    <= '1;
            pll_psda   <= PSDA_RST;
            pll_dutyda <= DUTY_RST;
        end else begin
            st        <= st_nxt;
            pulse_cnt <= pulse_nxt;
            to_cnt    <= to_nxt;
            stab_cnt  <= stab_nxt;
            set_cnt   <= set_nxt;
            stg_cnt   <= stg_nxt;
            ps_ack    <= ack_nxt;
            locked    <= lock_nxt;
            rst_out   <= rst_nxt;
            if (relock_inc) relock_cnt <= sat_inc(relock_cnt);
            if (latch_ps) begin
                pll_psda   <= ps_val;
                pll_dutyda <= duty_val;
            end
        end
    end

endmodule
